// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage RISC-V pipeline front end.
// Holds datapath widths, the PC step and the fetch buffer entry format.
package riscv_pkg;
    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc4;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush, used for the fetch output buffer and the
// in-flight address queue. Head is read combinationally (show-ahead).
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted when the head leaves the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop)  rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues IMEM word requests, drops
// responses made stale by redirects and buffers words toward IF/ID.
module if_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] instr_if,
    output logic [31:0] pc_plus4
);
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0] pc;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   drop_cnt;
    fetch_entry_t    held;

    logic            grant;
    logic            issue_ok;
    logic            live_rsp;
    logic            pop_out;
    fetch_entry_t    push_entry;
    fetch_entry_t    fifo_head;
    logic [FCW-1:0]  fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic [XLEN-1:0] aq_head;
    logic [OW-1:0]   aq_count;
    logic            aq_full;
    logic            aq_empty;

    // The address queue holds exactly the live (non-dropped) in-flight requests,
    // so aq_count equals outstanding - drop_cnt. Reserving FIFO space for each
    // of them up front means a response never has to be refused.
    assign issue_ok = (outstanding < OW'(MAX_OUTSTANDING)) && !aq_full && !fifo_full &&
                      (32'(aq_count) + 32'(fifo_count) < 32'(FIFO_DEPTH));
    assign imem_req  = !reset && !redirect_valid && issue_ok;
    assign imem_addr = pc;
    assign grant     = imem_req && imem_gnt;

    assign live_rsp   = imem_rvalid && (drop_cnt == '0) && !redirect_valid && !aq_empty;
    assign push_entry = '{instr: imem_rdata, pc4: aq_head + PC_STEP};
    assign pop_out    = if_valid && id_ready && !redirect_valid;

    assign if_valid = !fifo_empty;
    assign instr_if = fifo_empty ? held.instr : fifo_head.instr;
    assign pc_plus4 = fifo_empty ? held.pc4   : fifo_head.pc4;

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_addr_q (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (grant),
        .push_data (pc),
        .pop       (live_rsp),
        .head      (aq_head),
        .count     (aq_count),
        .full      (aq_full),
        .empty     (aq_empty)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_out_q (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (live_rsp),
        .push_data (push_entry),
        .pop       (pop_out),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            held        <= '0;
        end else begin
            if (redirect_valid) begin
                pc       <= align_word(redirect_pc);
                drop_cnt <= outstanding - OW'(imem_rvalid);
            end else begin
                if (grant) pc <= pc + PC_STEP;
                if (imem_rvalid && drop_cnt != '0) drop_cnt <= drop_cnt - OW'(1);
            end
            outstanding <= outstanding + OW'(grant) - OW'(imem_rvalid);
            // Outputs keep showing the last head once the buffer drains or flushes.
            if (!fifo_empty) held <= fifo_head;
        end
    end

    a_out_max: assert property (@(posedge clk) disable iff (reset)
        outstanding <= OW'(MAX_OUTSTANDING));
    a_drop_le: assert property (@(posedge clk) disable iff (reset)
        drop_cnt <= outstanding);
    a_rsp_req: assert property (@(posedge clk) disable iff (reset)
        imem_rvalid |-> outstanding != '0);
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed cycle table on a RESET_PC=0 instance, then
// a randomized run with a 3-cycle IMEM model on a RESET_PC=0xFFFF_FFF8 instance.
module tb_if_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // instance 0: directed table
    logic        reset0, redir0, gnt0, rvalid0, ready0;
    logic [31:0] rpc0, rdata0;
    logic        req0, valid0;
    logic [31:0] addr0, instr0, pc4_0;

    // instance 1: random + wrap
    logic        reset1, redir1, gnt1, rvalid1, ready1;
    logic [31:0] rpc1, rdata1;
    logic        req1, valid1;
    logic [31:0] addr1, instr1, pc4_1;

    if_fetch_unit dut0 (
        .clk(clk), .reset(reset0), .redirect_valid(redir0), .redirect_pc(rpc0),
        .imem_req(req0), .imem_addr(addr0), .imem_gnt(gnt0), .imem_rvalid(rvalid0),
        .imem_rdata(rdata0), .if_valid(valid0), .id_ready(ready0),
        .instr_if(instr0), .pc_plus4(pc4_0)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clk(clk), .reset(reset1), .redirect_valid(redir1), .redirect_pc(rpc1),
        .imem_req(req1), .imem_addr(addr1), .imem_gnt(gnt1), .imem_rvalid(rvalid1),
        .imem_rdata(rdata1), .if_valid(valid1), .id_ready(ready1),
        .instr_if(instr1), .pc_plus4(pc4_1)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1300_0013;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        gnt, rv;
        logic [31:0] raddr;
        logic        rdy, redir;
        logic [31:0] rpc;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evld;
        logic [31:0] epc4;
    } vec_t;

    function automatic vec_t mk(input logic gnt, input logic rv, input logic [31:0] raddr,
                                input logic rdy, input logic redir, input logic [31:0] rpc,
                                input logic ereq, input logic [31:0] eaddr,
                                input logic evld, input logic [31:0] epc4);
        vec_t v;
        v.gnt = gnt; v.rv = rv; v.raddr = raddr; v.rdy = rdy; v.redir = redir;
        v.rpc = rpc; v.ereq = ereq; v.eaddr = eaddr; v.evld = evld; v.epc4 = epc4;
        return v;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    initial begin
        vec_t        tv[$];
        pend_t       pend[$];
        logic [31:0] exp_fetch, exp_next, exp_instr, prev_pc4, prev_instr, tgt;
        logic        exp_inval, prev_stall, rdir;
        int          pops;

        reset0 = 1; redir0 = 0; rpc0 = 0; gnt0 = 0; rvalid0 = 0; rdata0 = 0; ready0 = 0;
        reset1 = 1; redir1 = 0; rpc1 = 0; gnt1 = 0; rvalid1 = 0; rdata1 = 0; ready1 = 0;

        //          gnt rv raddr     rdy rd rpc        ereq eaddr       evld epc4
        tv.push_back(mk(1, 0, 32'h0,   1, 0, 32'h0,    1, 32'h0,   0, 32'h0));
        tv.push_back(mk(1, 1, 32'h0,   1, 0, 32'h0,    1, 32'h4,   0, 32'h0));
        tv.push_back(mk(1, 1, 32'h4,   1, 0, 32'h0,    0, 32'h8,   1, 32'h4));
        tv.push_back(mk(1, 0, 32'h0,   1, 0, 32'h0,    1, 32'h8,   1, 32'h8));
        tv.push_back(mk(1, 1, 32'h8,   1, 0, 32'h0,    1, 32'hC,   0, 32'h8));
        tv.push_back(mk(1, 1, 32'hC,   1, 0, 32'h0,    0, 32'h10,  1, 32'hC));
        tv.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,    1, 32'h10,  1, 32'h10));
        tv.push_back(mk(1, 1, 32'h10,  0, 0, 32'h0,    0, 32'h14,  1, 32'h10));
        tv.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,    0, 32'h14,  1, 32'h10));
        tv.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,    0, 32'h14,  1, 32'h10));
        tv.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,    0, 32'h14,  1, 32'h10));
        tv.push_back(mk(1, 0, 32'h0,   1, 0, 32'h0,    0, 32'h14,  1, 32'h10));
        tv.push_back(mk(1, 0, 32'h0,   1, 0, 32'h0,    1, 32'h14,  1, 32'h14));
        tv.push_back(mk(1, 1, 32'h14,  1, 0, 32'h0,    1, 32'h18,  0, 32'h14));
        tv.push_back(mk(1, 0, 32'h0,   1, 0, 32'h0,    0, 32'h1C,  1, 32'h18));
        tv.push_back(mk(1, 0, 32'h0,   1, 0, 32'h0,    1, 32'h1C,  0, 32'h18));
        tv.push_back(mk(1, 0, 32'h0,   1, 1, 32'h100,  0, 32'h20,  0, 32'h18));
        tv.push_back(mk(1, 1, 32'h18,  1, 0, 32'h0,    0, 32'h100, 0, 32'h18));
        tv.push_back(mk(1, 1, 32'h1C,  1, 0, 32'h0,    1, 32'h100, 0, 32'h18));
        tv.push_back(mk(0, 1, 32'h100, 1, 0, 32'h0,    1, 32'h104, 0, 32'h18));
        tv.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,    1, 32'h104, 1, 32'h104));
        tv.push_back(mk(0, 1, 32'h104, 1, 1, 32'h203,  0, 32'h108, 1, 32'h104));
        tv.push_back(mk(0, 0, 32'h0,   1, 0, 32'h0,    1, 32'h200, 0, 32'h104));
        tv.push_back(mk(1, 0, 32'h0,   1, 0, 32'h0,    1, 32'h200, 0, 32'h104));
        tv.push_back(mk(0, 1, 32'h200, 1, 0, 32'h0,    1, 32'h204, 0, 32'h104));
        tv.push_back(mk(0, 0, 32'h0,   1, 0, 32'h0,    1, 32'h204, 1, 32'h204));

        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        chk("rst0.req",   {31'd0, req0},   32'd0);
        chk("rst0.valid", {31'd0, valid0}, 32'd0);
        chk("rst0.instr", instr0,          32'd0);
        chk("rst0.pc4",   pc4_0,           32'd0);
        chk("rst0.addr",  addr0,           32'h0);
        chk("rst1.req",   {31'd0, req1},   32'd0);
        chk("rst1.addr",  addr1,           32'hFFFF_FFF8);

        // Directed table: cycle 0 is the first cycle with reset low.
        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            reset0  = 0;
            gnt0    = tv[i].gnt;
            rvalid0 = tv[i].rv;
            rdata0  = tv[i].rv ? instr_of(tv[i].raddr) : 32'hDEAD_BEEF;
            ready0  = tv[i].rdy;
            redir0  = tv[i].redir;
            rpc0    = tv[i].rpc;
            #2;
            exp_instr = (tv[i].epc4 == 32'h0) ? 32'h0 : instr_of(tv[i].epc4 - 32'd4);
            chk($sformatf("t%0d.req", i),   {31'd0, req0},   {31'd0, tv[i].ereq});
            chk($sformatf("t%0d.addr", i),  addr0,           tv[i].eaddr);
            chk($sformatf("t%0d.valid", i), {31'd0, valid0}, {31'd0, tv[i].evld});
            chk($sformatf("t%0d.pc4", i),   pc4_0,           tv[i].epc4);
            chk($sformatf("t%0d.instr", i), instr0,          exp_instr);
        end
        @(negedge clk);
        gnt0 = 0; rvalid0 = 0; ready0 = 0; redir0 = 0;

        // Random run against an in-order 3-cycle IMEM and a sequential-PC reference.
        exp_fetch  = 32'hFFFF_FFF8;
        exp_next   = 32'hFFFF_FFFC;
        exp_inval  = 0;
        prev_stall = 0;
        pops       = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (cyc == 1500 || cyc == 1501) begin
                reset1 = 1; redir1 = 0; gnt1 = 0; rvalid1 = 0; ready1 = 0;
                pend.delete();
                exp_fetch  = 32'hFFFF_FFF8;
                exp_next   = 32'hFFFF_FFFC;
                prev_stall = 0;
                exp_inval  = 1;
                #2;
                chk("mrst.req", {31'd0, req1}, 32'd0);
                continue;
            end
            reset1 = 0;
            rdir   = (cyc > 20) && ($urandom_range(0, 39) == 0);
            tgt    = $urandom;
            redir1 = rdir;
            rpc1   = tgt;
            gnt1   = ($urandom_range(0, 3) != 0);
            ready1 = ($urandom_range(0, 3) != 0);
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                rvalid1 = 1;
                rdata1  = instr_of(pend[0].addr);
            end else begin
                rvalid1 = 0;
                rdata1  = $urandom;
            end
            #2;
            chk("r.outstanding_le2", {31'd0, pend.size() <= 2}, 32'd1);
            if (rdir) chk("r.req_in_redirect", {31'd0, req1}, 32'd0);
            if (exp_inval) begin
                chk("r.valid_after_flush", {31'd0, valid1}, 32'd0);
                exp_inval = 0;
            end
            if (prev_stall) begin
                chk("r.hold.valid", {31'd0, valid1}, 32'd1);
                chk("r.hold.pc4",   pc4_1,           prev_pc4);
                chk("r.hold.instr", instr1,          prev_instr);
            end
            prev_stall = valid1 && !ready1 && !rdir;
            prev_pc4   = pc4_1;
            prev_instr = instr1;
            if (req1 && gnt1) begin
                chk("r.fetch_addr", addr1, exp_fetch);
                pend.push_back('{addr: addr1, due: cyc + 3});
                exp_fetch = exp_fetch + 32'd4;
            end
            if (valid1 && ready1 && !rdir) begin
                chk("r.out.pc4",   pc4_1,  exp_next);
                chk("r.out.instr", instr1, instr_of(exp_next - 32'd4));
                exp_next = exp_next + 32'd4;
                pops++;
            end
            if (rvalid1) void'(pend.pop_front());
            if (rdir) begin
                exp_fetch = {tgt[31:2], 2'b00};
                exp_next  = {tgt[31:2], 2'b00} + 32'd4;
                exp_inval = 1;
            end
        end
        chk("r.progress", {31'd0, pops > 300}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
